simple_cpu: RTL and testbench

//   Minimal multi-cycle 8-bit CPU: 4-entry register file, 2-function ALU (ADD/SUB),
//   32-entry data memory with register+immediate LOAD/STORE. Instruction word is driven

---
 rtl/simple_cpu.sv | 76 +++++++
 tb/tb_simple_cpu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/simple_cpu.sv
// simple_cpu: 3-cycle 8-bit teaching core with 4 registers, ADD/SUB ALU and 32-word data memory
// Define SIMPLE_CPU_MEM_CLEAR_EN to make reset also clear the data memory.
module simple_cpu #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);
  typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;
  state_t                  state;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [DATA_WIDTH-1:0]   reg_file [0:3];
  logic [DATA_WIDTH-1:0]   data_mem [0:2**ADDR_BITS-1];
  logic [DATA_WIDTH-1:0]   wb_data;
  logic [ADDR_BITS-1:0]    wb_addr;
  logic [1:0]              cls, x1, x2, x3;
  logic [7:0]              imm;
  logic [3:0]              func;
  logic [DATA_WIDTH-1:0]   a, b, alu;
  logic [ADDR_BITS-1:0]    addr;
  logic                    reg_we, mem_we;
  assign cls    = ir[19:18];
  assign x1     = ir[17:16];
  assign x2     = ir[15:14];
  assign x3     = ir[13:12];
  assign imm    = ir[11:4];
  assign func   = ir[3:0];
  assign a      = reg_file[x2];
  assign b      = reg_file[x3];
  assign alu    = func == 4'd1 ? a - b : a + b;
  // full-width sum first so the carry is dropped only by the final truncation
  assign addr   = ADDR_BITS'({1'b0, a} + (DATA_WIDTH+1)'(imm));
  assign reg_we = state == WB && (cls == 2'b10 || (cls == 2'b01 && func <= 4'd1));
  assign mem_we = state == WB && cls == 2'b11;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      ir      <= '0;
      wb_data <= '0;
      wb_addr <= '0;
      for (int i = 0; i < 4; i++) reg_file[i] <= DATA_WIDTH'(i);
    end else begin
      unique case (state)
        FETCH: begin
          ir    <= instruction;
          state <= EXEC;
        end
        EXEC: begin
          wb_data <= cls == 2'b10 ? data_mem[addr] : alu;
          wb_addr <= addr;
          state   <= WB;
        end
        default: begin
          if (reg_we) reg_file[x1] <= wb_data;
          state <= FETCH;
        end
      endcase
    end
  end
`ifdef SIMPLE_CPU_MEM_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) data_mem[i] <= '0;
    end else if (mem_we) begin
      data_mem[wb_addr] <= reg_file[x1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[wb_addr] <= reg_file[x1];
  end
`endif
endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: directed test of simple_cpu against an instruction-level model of registers and memory
module tb_simple_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] instruction = '0;
  int          checks = 0;
  int          errors = 0;
  logic        check_due = 1'b0;
  logic [7:0]  m_reg [4];
  logic [7:0]  m_mem [32];
  bit          m_known [32];

  simple_cpu dut (.clk(clk), .rst(rst), .instruction(instruction));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_exec(input logic [19:0] ins);
    int cls = ins[19:18], x1 = ins[17:16], x2 = ins[15:14], x3 = ins[13:12];
    int imm = ins[11:4], fn = ins[3:0];
    int ea = (int'(m_reg[x2]) + imm) % 32;
    if (cls == 1 && fn == 0) m_reg[x1] = 8'((int'(m_reg[x2]) + int'(m_reg[x3])) % 256);
    if (cls == 1 && fn == 1) m_reg[x1] = 8'((int'(m_reg[x2]) - int'(m_reg[x3]) + 256) % 256);
    if (cls == 2) m_reg[x1] = m_mem[ea];
    if (cls == 3) begin
      m_mem[ea] = m_reg[x1];
      m_known[ea] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'(i);
`ifdef SIMPLE_CPU_MEM_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b1;
    end
`endif
  endfunction

  always @(negedge clk) begin
    if (check_due) begin
      for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), 32'(dut.reg_file[i]), 32'(m_reg[i]));
      for (int i = 0; i < 32; i++)
        if (m_known[i]) chk($sformatf("mem%0d", i), 32'(dut.data_mem[i]), 32'(m_mem[i]));
      chk("state_fetch", 32'(dut.state), 32'd0);
      check_due = 1'b0;
    end
  end

  task automatic finish_check();
    check_due = 1'b1;
    wait (!check_due);
  endtask

  task automatic reset_tail();
    @(posedge clk);
    #1 rst = 1'b0;
    instruction = '0;
    model_reset();
    finish_check();
  endtask

  task automatic run(input logic [19:0] ins);
    instruction = ins;
    @(posedge clk);
    #1 instruction = 20'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1 model_exec(ins);
    finish_check();
  endtask

  task automatic run_lit(input string nm, input logic [19:0] ins, input bit is_mem,
                         input int idx, input logic [7:0] val);
    run(ins);
    if (is_mem) begin
      chk({nm, "_dut"}, 32'(dut.data_mem[idx]), 32'(val));
      chk({nm, "_model"}, 32'(m_mem[idx]), 32'(val));
    end else begin
      chk({nm, "_dut"}, 32'(dut.reg_file[idx]), 32'(val));
      chk({nm, "_model"}, 32'(m_reg[idx]), 32'(val));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end
    #2;
    reset_tail();
    for (int i = 0; i < 4; i++) chk($sformatf("rst_reg%0d", i), 32'(dut.reg_file[i]), i);
    run_lit("add_r0",      20'b01_00_01_11_00000000_0000, 0, 0,  8'd4);
    run_lit("add_r1",      20'b01_01_00_11_00000000_0000, 0, 1,  8'd7);
    run_lit("sub_r3",      20'b01_11_00_10_00000000_0001, 0, 3,  8'd2);
    run_lit("st_mem17",    20'b11_01_10_00_00001111_0000, 1, 17, 8'd7);
    run_lit("st_mem24",    20'b11_00_11_00_00010110_0000, 1, 24, 8'd4);
    run_lit("ld_r3",       20'b10_11_10_00_00001111_0000, 0, 3,  8'd7);
    run_lit("badfunc_r0",  20'b01_00_01_01_00000000_0101, 0, 0,  8'd4);
    run_lit("nop_r0",      20'b00_00_01_01_11111111_0000, 0, 0,  8'd4);
    run_lit("st_mem3",     20'b11_00_10_00_00000001_0000, 1, 3,  8'd4);
    // STORE of r1 to mem[3], aborted by reset while in WB
    instruction = 20'b11_01_10_00_00000001_0000;
    @(posedge clk);
    #1 instruction = 20'($urandom);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_state", 32'(dut.state), 32'd0);
    reset_tail();
`ifndef SIMPLE_CPU_MEM_CLEAR_EN
    chk("rst_abort_mem3", 32'(dut.data_mem[3]), 32'd4);
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("rst2_reg%0d", i), 32'(dut.reg_file[i]), i);
    run_lit("sub_wrap_r0", 20'b01_00_00_01_00000000_0001, 0, 0,  8'hFF);
    run(20'b01_10_11_11_00000000_0000);
    run(20'b01_10_10_10_00000000_0000);
    run(20'b01_10_10_10_00000000_0000);
    run(20'b01_10_10_11_00000000_0000);
    run(20'b01_10_10_11_00000000_0000);
    run_lit("build_r2",    20'b01_10_10_01_00000000_0000, 0, 2,  8'd31);
    run_lit("st_wrap31",   20'b11_11_10_00_00000010_0000, 1, 1,  8'd3);
    run_lit("st_wrapff",   20'b11_01_00_00_00000010_0000, 1, 1,  8'd1);
    run_lit("ld_wrap",     20'b10_11_00_00_00000010_0000, 0, 3,  8'd1);
    run_lit("add_wrap",    20'b01_00_00_00_00000000_0000, 0, 0,  8'hFE);
    run_lit("st_imm255",   20'b11_00_10_00_11111111_0000, 1, 30, 8'hFE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
